dbg_window_ctrl: RTL and testbench
==================================

# dbg_window_ctrl

Memory-mapped, multi-channel controller that drives per-core halt and reset requests during programmable windows of a free-running cycle counter. It replaces the hard-coded counter/window logic that gates `haltpin` and `core_rst_n` in the debug system top. It sits on the system bus as a device next to `timer` and `simulator_ctrl`. Each channel adds software-programmable windows, a periodic mode, and end-of-window interrupts.

## Interface

Parameters:
- `NumChannels`, 2: independent window channels, 1..4.
- `CountWidth`, 32: width of the global counter and per-channel compare values, 8..32.
- `DataWidth`, 32: bus data width; must be 32.
- `AddressWidth`, 32: bus address width.

Ports:
- `clk_i`  in  1  system clock.
- `rst_i`  in  1  asynchronous, active-high reset.
- `req_i`  in  1  bus request; always granted the same cycle.
- `we_i`  in  1  write enable.
- `be_i`  in  4  byte enables (writes only).
- `addr_i`  in  AddressWidth  byte address; only `[7:0]` decoded.
- `wdata_i`  in  32  write data.
- `rvalid_o`  out  1  response valid, one cycle after `req_i`.
- `rdata_o`  out  32  read data, valid with `rvalid_o`; 0 for writes and errors.
- `err_o`  out  1  error, valid with `rvalid_o`.
- `halt_o`  out  NumChannels  per-channel halt request, active high.
- `core_rst_n_o`  out  NumChannels  per-channel core reset, active low.
- `irq_o`  out  1  level interrupt: OR over `DONE & IRQ_EN`.

## Operation

Register map. Unused bits read 0. Registers are zero-extended from CountWidth.
- 0x00 `COUNT` (RW): global counter.
- 0x04 `DONE` (R/W1C): bit c is set when channel c's window ends.
- 0x08 `GCTRL` (RW): bit0 `run`, reset value 1.
- 0x0C `IRQ_EN` (RW): bits `[NumChannels-1:0]`.
- Channel c base = 0x40 + 0x10·c:
  - +0x0 `CTRL`: bit0 `en`, bit1 `action` (0 = halt, 1 = reset), bit2 `periodic`.
  - +0x4 `START`.
  - +0x8 `END`.
  - +0xC `PERIOD`.

Bus rules:
- Any other address, including channel slots ≥ NumChannels, returns `err_o`=1 with `rdata_o`=0. Writes to such addresses have no effect.
- Writes honour `be_i` per byte.

Counting:
- `COUNT` increments by 1 per cycle while `run`=1.
- It wraps from 2^CountWidth−1 to 0.
- A bus write to `COUNT` takes priority over the increment in that cycle.

Channel compare value v:
- v = the channel phase counter if `periodic`=1 and `PERIOD`≠0; otherwise v = `COUNT`.
- The phase counter advances with `run`.
- It wraps from `PERIOD`−1 to 0.
- It clears to 0 on any write to that channel's `CTRL` or `PERIOD`.

Window:
- `hit` = `en` & (`START` ≤ v) & (v < `END`), unsigned compare.
- If `START` ≥ `END`, the channel never hits.
- Per-channel registered `active_q` <= `hit`.
- `halt_o[c]` = `active_q` & ~`action`.
- `core_rst_n_o[c]` = ~(`active_q` & `action`).

DONE:
- Set on a falling edge of `active_q` caused by the compare: `active_q`=1, `hit`=0, and `en` still 1.
- Clearing `en` deasserts the output on the next cycle without setting `DONE`.
- A same-cycle W1C clear and hardware set: set wins.

`irq_o` is registered from the current `DONE & IRQ_EN`.

## Timing

Reset values:
- `COUNT`, `DONE`, `IRQ_EN`, and all channel registers: 0.
- `run`: 1.
- `active_q`: 0.

Output reset values:
- `halt_o`: 0.
- `core_rst_n_o`: all 1.
- `rvalid_o`, `err_o`, `irq_o`: 0.
- `rdata_o`: 0.

Latency and handshake:
- Output latency is 1 cycle from the counter value that satisfies the window.
- A window [S, E) gives exactly E−S consecutive asserted cycles per pass.
- Read latency is 1 cycle. `rdata_o` returns register values as sampled in the request cycle, before that cycle's write or increment.
- Back-to-back requests are accepted every cycle.
- Register writes take effect on the compare in the following cycle.
- `DONE` sets one cycle after the last asserted cycle. `irq_o` follows one cycle later.

Boundary conditions:
- Freeze (`run`=0): outputs hold their current state; no `DONE` edge.
- Counter wrap inside a window (`START` < `END`): the window is re-entered after wrap. No wrap-around windows.
- Asserting `rst_i` mid-window forces `halt_o`=0 and `core_rst_n_o`=1 asynchronously.

## Test plan

- **Reset defaults:** after reset release, read `GCTRL`. Expect 1, `COUNT` incrementing, `halt_o`=0, `core_rst_n_o`=all 1.
- **Halt window:**
  - Stimulus: write `COUNT`=0; channel 0 `START`=5, `END`=8, `CTRL`=0x1.
  - Expect `halt_o[0]` high for exactly 3 cycles, first when `COUNT` reads 6.
  - Expect `DONE[0]`=1 afterwards; with `IRQ_EN`=1, `irq_o`=1 until W1C 0x1.
- **Reset action, periodic:**
  - Stimulus: channel 1 `CTRL`=0x7, `PERIOD`=10, `START`=2, `END`=4.
  - Expect `core_rst_n_o[1]` low 2 cycles out of every 10.
  - Expect `DONE[1]` to re-set each period.
- **Edge cases:**
  - `START`=8, `END`=8: never asserts.
  - Clear `en` mid-window: output drops next cycle, `DONE` stays 0.
  - `run`=0 mid-window: output holds.
- **Bus errors and byte enables:**
  - Read 0x40+0x10·NumChannels: expect `err_o`=1, `rdata_o`=0.
  - Write `START` with `be_i`=0x1, data 0xFFFFFFFF: expect `START`=0x000000FF.
- **Collisions:**
  - W1C of `DONE` in the same cycle as a window end: `DONE` stays set.
  - `COUNT` write while running: the written value is read back the next cycle (not value+1), then it increments.

Source files
------------

// File: rtl/dbg_window_ctrl.sv
// -----------------------------------------------------------------------------
// dbg_window_ctrl
//
// Memory-mapped window controller for per-core halt / reset requests. A global
// free-running counter (or, per channel, a periodic phase counter) is compared
// against a programmable [START, END) window. While a channel's window is
// active it drives either a halt request or an active-low core reset. The end
// of each window sets a sticky DONE bit that can raise a level interrupt.
//
// Ports:
//   clk_i         system clock
//   rst_i         asynchronous active-high reset
//   req_i         bus request, always granted in the same cycle
//   we_i          write enable
//   be_i          byte enables (writes only)
//   addr_i        byte address, only [7:0] decoded
//   wdata_i       write data
//   rvalid_o      response valid, one cycle after req_i
//   rdata_o       read data (0 for writes and errors)
//   err_o         decode error, valid with rvalid_o
//   halt_o        per-channel halt request, active high
//   core_rst_n_o  per-channel core reset, active low
//   irq_o         level interrupt: OR of DONE & IRQ_EN, registered
//
// Register map (unused bits read 0):
//   0x00 COUNT   0x04 DONE (W1C)   0x08 GCTRL (bit0 run)   0x0C IRQ_EN
//   0x40 + 0x10*c : CTRL {periodic, action, en}, START, END, PERIOD
// -----------------------------------------------------------------------------
module dbg_window_ctrl #(
  parameter int NumChannels  = 2,
  parameter int CountWidth   = 32,
  parameter int DataWidth    = 32,
  parameter int AddressWidth = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  input  logic                    we_i,
  input  logic [3:0]              be_i,
  input  logic [AddressWidth-1:0] addr_i,
  input  logic [DataWidth-1:0]    wdata_i,
  output logic                    rvalid_o,
  output logic [DataWidth-1:0]    rdata_o,
  output logic                    err_o,
  output logic [NumChannels-1:0]  halt_o,
  output logic [NumChannels-1:0]  core_rst_n_o,
  output logic                    irq_o
);

  localparam logic [CountWidth-1:0] CntOne = {{(CountWidth-1){1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------
  // Address decode
  // ---------------------------------------------------------------------------
  logic [7:0]             addr_lo;
  logic [1:0]             ch_idx;
  logic [1:0]             reg_idx;
  logic                   wr_req;
  logic                   sel_count;
  logic                   sel_done;
  logic                   sel_gctrl;
  logic                   sel_irq_en;
  logic                   sel_ch_region;
  logic                   addr_ok;
  logic [NumChannels-1:0] ch_sel;
  logic                   unused_addr;

  assign addr_lo       = addr_i[7:0];
  assign ch_idx        = addr_lo[5:4];
  assign reg_idx       = addr_lo[3:2];
  assign wr_req        = req_i & we_i;
  assign sel_count     = (addr_lo == 8'h00);
  assign sel_done      = (addr_lo == 8'h04);
  assign sel_gctrl     = (addr_lo == 8'h08);
  assign sel_irq_en    = (addr_lo == 8'h0C);
  // 0x40..0x7F holds up to four channel slots; slots past NumChannels never
  // assert their ch_sel bit and therefore decode as errors.
  assign sel_ch_region = (addr_lo[7:6] == 2'b01) && (addr_lo[1:0] == 2'b00);
  assign addr_ok       = sel_count | sel_done | sel_gctrl | sel_irq_en | (|ch_sel);
  assign unused_addr   = ^addr_i[AddressWidth-1:8];

  // Byte-enable merge: new = (old & ~wmask) | (wdata & wmask)
  logic [DataWidth-1:0] wmask;
  logic [DataWidth-1:0] wdata_m;

  for (genvar gi = 0; gi < 4; gi++) begin : g_wmask
    assign wmask[8*gi +: 8] = {8{be_i[gi]}};
  end
  assign wdata_m = wdata_i & wmask;

  // ---------------------------------------------------------------------------
  // Global registers
  // ---------------------------------------------------------------------------
  logic [CountWidth-1:0]  count_q, count_d;
  logic [NumChannels-1:0] done_q, done_d;
  logic [NumChannels-1:0] done_set;
  logic [NumChannels-1:0] irq_en_q, irq_en_d;
  logic                   run_q, run_d;
  logic                   irq_q, irq_d;
  logic                   rvalid_q;
  logic                   err_q, err_d;
  logic [DataWidth-1:0]   rdata_q, rdata_d;
  logic [DataWidth-1:0]   ch_rdata [NumChannels];

  always_comb begin
    count_d  = count_q;
    done_d   = done_q;
    irq_en_d = irq_en_q;
    run_d    = run_q;

    // A bus write to COUNT overrides that cycle's increment.
    if (wr_req && sel_count) begin
      count_d = (count_q & ~wmask[CountWidth-1:0]) | wdata_m[CountWidth-1:0];
    end else if (run_q) begin
      count_d = count_q + CntOne;
    end

    // W1C clear first, hardware set second so a colliding set survives.
    if (wr_req && sel_done) begin
      done_d = done_q & ~wdata_m[NumChannels-1:0];
    end
    done_d = done_d | done_set;

    if (wr_req && sel_irq_en) begin
      irq_en_d = (irq_en_q & ~wmask[NumChannels-1:0]) | wdata_m[NumChannels-1:0];
    end

    if (wr_req && sel_gctrl) begin
      run_d = (run_q & ~wmask[0]) | wdata_m[0];
    end

    irq_d = |(done_q & irq_en_q);
  end

  // Read response: values sampled in the request cycle, before any update.
  always_comb begin
    rdata_d = '0;
    err_d   = 1'b0;
    if (req_i) begin
      if (!addr_ok) begin
        err_d = 1'b1;
      end else if (!we_i) begin
        if (sel_count) begin
          rdata_d = DataWidth'(count_q);
        end else if (sel_done) begin
          rdata_d = DataWidth'(done_q);
        end else if (sel_gctrl) begin
          rdata_d = DataWidth'(run_q);
        end else if (sel_irq_en) begin
          rdata_d = DataWidth'(irq_en_q);
        end else begin
          for (int c = 0; c < NumChannels; c++) begin
            if (ch_sel[c]) begin
              rdata_d = ch_rdata[c];
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      count_q  <= '0;
      done_q   <= '0;
      irq_en_q <= '0;
      run_q    <= 1'b1;
      irq_q    <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= '0;
    end else begin
      count_q  <= count_d;
      done_q   <= done_d;
      irq_en_q <= irq_en_d;
      run_q    <= run_d;
      irq_q    <= irq_d;
      rvalid_q <= req_i;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;
  assign err_o    = err_q;
  assign irq_o    = irq_q;

  // ---------------------------------------------------------------------------
  // Window channels
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < NumChannels; gi++) begin : g_ch
    localparam logic [1:0] ChIdx = 2'(gi);

    logic [2:0]            ctrl_q, ctrl_d;
    logic [CountWidth-1:0] start_q, start_d;
    logic [CountWidth-1:0] end_q, end_d;
    logic [CountWidth-1:0] period_q, period_d;
    logic [CountWidth-1:0] phase_q, phase_d;
    logic [CountWidth-1:0] cmp_val;
    logic                  active_q;
    logic                  hit;
    logic                  wr_ch;
    logic                  wr_ctrl;
    logic                  wr_start;
    logic                  wr_end;
    logic                  wr_period;

    assign ch_sel[gi] = sel_ch_region && (ch_idx == ChIdx);
    assign wr_ch      = wr_req & ch_sel[gi];
    assign wr_ctrl    = wr_ch && (reg_idx == 2'd0);
    assign wr_start   = wr_ch && (reg_idx == 2'd1);
    assign wr_end     = wr_ch && (reg_idx == 2'd2);
    assign wr_period  = wr_ch && (reg_idx == 2'd3);

    always_comb begin
      ctrl_d   = ctrl_q;
      start_d  = start_q;
      end_d    = end_q;
      period_d = period_q;
      phase_d  = phase_q;

      if (wr_ctrl) begin
        ctrl_d = (ctrl_q & ~wmask[2:0]) | wdata_m[2:0];
      end
      if (wr_start) begin
        start_d = (start_q & ~wmask[CountWidth-1:0]) | wdata_m[CountWidth-1:0];
      end
      if (wr_end) begin
        end_d = (end_q & ~wmask[CountWidth-1:0]) | wdata_m[CountWidth-1:0];
      end
      if (wr_period) begin
        period_d = (period_q & ~wmask[CountWidth-1:0]) | wdata_m[CountWidth-1:0];
      end

      // Reprogramming mode or period restarts the phase so the new period
      // begins cleanly. The >= also recovers if phase ever exceeds period.
      if (wr_ctrl || wr_period) begin
        phase_d = '0;
      end else if (run_q) begin
        phase_d = (phase_q >= period_q - CntOne) ? '0 : phase_q + CntOne;
      end
    end

    // PERIOD = 0 falls back to the global counter even in periodic mode.
    assign cmp_val = (ctrl_q[2] && (period_q != '0)) ? phase_q : count_q;
    assign hit     = ctrl_q[0] && (start_q <= cmp_val) && (cmp_val < end_q);

    // Only a compare-driven falling edge marks completion; disabling the
    // channel (en = 0) drops the output silently.
    assign done_set[gi] = active_q & ~hit & ctrl_q[0];

    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        ctrl_q   <= '0;
        start_q  <= '0;
        end_q    <= '0;
        period_q <= '0;
        phase_q  <= '0;
        active_q <= 1'b0;
      end else begin
        ctrl_q   <= ctrl_d;
        start_q  <= start_d;
        end_q    <= end_d;
        period_q <= period_d;
        phase_q  <= phase_d;
        active_q <= hit;
      end
    end

    assign halt_o[gi]       = active_q & ~ctrl_q[1];
    assign core_rst_n_o[gi] = ~(active_q & ctrl_q[1]);

    assign ch_rdata[gi] = (reg_idx == 2'd0) ? DataWidth'(ctrl_q)  :
                          (reg_idx == 2'd1) ? DataWidth'(start_q) :
                          (reg_idx == 2'd2) ? DataWidth'(end_q)   :
                                              DataWidth'(period_q);
  end

endmodule

// File: tb/tb_dbg_window_ctrl.sv
// -----------------------------------------------------------------------------
// Directed self-checking bench for dbg_window_ctrl (2 channels, 32-bit count).
// Inputs change and outputs are sampled on the falling clock edge; each bus
// transaction occupies exactly one clock cycle.
// -----------------------------------------------------------------------------
module tb_dbg_window_ctrl;

  localparam int NumCh = 2;

  logic             clk;
  logic             rst;
  logic             req;
  logic             we;
  logic [3:0]       be;
  logic [31:0]      addr;
  logic [31:0]      wdata;
  logic             rvalid_o;
  logic [31:0]      rdata_o;
  logic             err_o;
  logic [NumCh-1:0] halt_o;
  logic [NumCh-1:0] core_rst_n_o;
  logic             irq_o;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] rd;
  logic        er;

  dbg_window_ctrl #(
    .NumChannels (NumCh),
    .CountWidth  (32),
    .DataWidth   (32),
    .AddressWidth(32)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .req_i       (req),
    .we_i        (we),
    .be_i        (be),
    .addr_i      (addr),
    .wdata_i     (wdata),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .halt_o      (halt_o),
    .core_rst_n_o(core_rst_n_o),
    .irq_o       (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One-cycle bus transaction; leaves response in rd / er.
  task automatic bus(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    req   = 1'b1;
    we    = w;
    addr  = {24'h0, a};
    wdata = d;
    be    = b;
    @(negedge clk);
    req   = 1'b0;
    we    = 1'b0;
    be    = 4'h0;
    wdata = 32'h0;
    rd    = rdata_o;
    er    = err_o;
    chk("rvalid", 32'(rvalid_o), 32'd1);
    $display("[TB] bus %s addr=0x%02h wdata=0x%08h be=0x%h -> rdata=0x%08h err=%0b",
             w ? "WR" : "RD", a, d, b, rd, er);
  endtask

  task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    bus(1'b1, a, d, b);
    chk({tag, "_err"}, 32'(er), 32'd0);
    chk({tag, "_rdata"}, rd, 32'd0);
  endtask

  task automatic rdchk(input string tag, input logic [7:0] a, input logic [31:0] exp);
    bus(1'b0, a, 32'h0, 4'h0);
    chk(tag, rd, exp);
    chk({tag, "_err"}, 32'(er), 32'd0);
  endtask

  initial begin
    rst   = 1'b1;
    req   = 1'b0;
    we    = 1'b0;
    be    = 4'h0;
    addr  = 32'h0;
    wdata = 32'h0;

    // ---------------- reset defaults ----------------
    tick(2);
    chk("rst_halt", 32'(halt_o), 32'h0);
    chk("rst_rstn", 32'(core_rst_n_o), 32'h3);
    chk("rst_rvalid", 32'(rvalid_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    chk("rst_irq", 32'(irq_o), 32'h0);
    chk("rst_rdata", rdata_o, 32'h0);
    rst = 1'b0;
    rdchk("count_first", 8'h00, 32'd0);
    rdchk("count_second", 8'h00, 32'd1);
    rdchk("gctrl_rst", 8'h08, 32'd1);
    rdchk("done_rst", 8'h04, 32'd0);
    rdchk("ctrl0_rst", 8'h40, 32'd0);

    // ---------------- halt window [5,8) on channel 0 ----------------
    wr("cnt_far", 8'h00, 32'h100, 4'hF);
    wr("irq_en", 8'h0C, 32'h1, 4'hF);
    wr("start0", 8'h44, 32'd5, 4'hF);
    wr("end0", 8'h48, 32'd8, 4'hF);
    wr("ctrl0", 8'h40, 32'h1, 4'hF);
    wr("cnt_zero", 8'h00, 32'h0, 4'hF);
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      chk($sformatf("halt0_k%0d", k), 32'(halt_o[0]), 32'((k >= 6) && (k <= 8)));
      chk($sformatf("irq_k%0d", k), 32'(irq_o), 32'(k >= 10));
    end
    rdchk("done_after_halt", 8'h04, 32'h1);
    wr("w1c_done0", 8'h04, 32'h1, 4'hF);
    tick(1);
    chk("irq_cleared", 32'(irq_o), 32'h0);
    rdchk("done_cleared", 8'h04, 32'h0);
    wr("ctrl0_off", 8'h40, 32'h0, 4'hF);

    // ---------------- periodic reset window on channel 1 ----------------
    wr("period1", 8'h5C, 32'd10, 4'hF);
    wr("start1", 8'h54, 32'd2, 4'hF);
    wr("end1", 8'h58, 32'd4, 4'hF);
    wr("ctrl1", 8'h50, 32'h7, 4'hF);
    for (int k = 1; k <= 30; k++) begin
      if ((k % 10) == 8) begin
        wr($sformatf("w1c1_k%0d", k), 8'h04, 32'h2, 4'hF);
      end else begin
        bus(1'b0, 8'h04, 32'h0, 4'h0);
        chk($sformatf("done1_k%0d", k), rd, ((k % 10) == 6 || (k % 10) == 7) ? 32'h2 : 32'h0);
      end
      chk($sformatf("rstn1_k%0d", k), 32'(core_rst_n_o),
          ((k % 10) == 3 || (k % 10) == 4) ? 32'h1 : 32'h3);
    end
    chk("halt_periodic", 32'(halt_o), 32'h0);
    chk("irq_masked", 32'(irq_o), 32'h0);
    wr("ctrl1_off", 8'h50, 32'h0, 4'hF);

    // ---------------- START == END never asserts ----------------
    wr("start0_eq", 8'h44, 32'd8, 4'hF);
    wr("end0_eq", 8'h48, 32'd8, 4'hF);
    wr("ctrl0_eq", 8'h40, 32'h1, 4'hF);
    wr("cnt_eq", 8'h00, 32'h0, 4'hF);
    for (int k = 1; k <= 14; k++) begin
      tick(1);
      chk($sformatf("halt0_eq_k%0d", k), 32'(halt_o[0]), 32'h0);
    end
    rdchk("done_eq", 8'h04, 32'h0);

    // ---------------- clear en mid-window ----------------
    wr("start0_b", 8'h44, 32'd3, 4'hF);
    wr("end0_b", 8'h48, 32'd10, 4'hF);
    wr("cnt_b", 8'h00, 32'h0, 4'hF);
    tick(5);
    chk("halt0_in_window", 32'(halt_o[0]), 32'h1);
    wr("ctrl0_clear_en", 8'h40, 32'h0, 4'hF);
    chk("halt0_en_write_cycle", 32'(halt_o[0]), 32'h1);
    tick(1);
    chk("halt0_en_dropped", 32'(halt_o[0]), 32'h0);
    rdchk("done_en_clear", 8'h04, 32'h0);

    // ---------------- freeze mid-window ----------------
    wr("cnt_far_c", 8'h00, 32'h100, 4'hF);
    wr("ctrl0_c", 8'h40, 32'h1, 4'hF);
    wr("cnt_c", 8'h00, 32'h0, 4'hF);
    tick(4);
    chk("halt0_pre_freeze", 32'(halt_o[0]), 32'h1);
    wr("run_off", 8'h08, 32'h0, 4'hF);
    for (int k = 1; k <= 8; k++) begin
      tick(1);
      chk($sformatf("halt0_frozen_k%0d", k), 32'(halt_o[0]), 32'h1);
    end
    rdchk("count_frozen", 8'h00, 32'd5);
    rdchk("done_frozen", 8'h04, 32'h0);

    // ---------------- resume, W1C collides with window end ----------------
    wr("run_on", 8'h08, 32'h1, 4'hF);
    tick(5);
    chk("halt0_last_cycle", 32'(halt_o[0]), 32'h1);
    wr("w1c_collide", 8'h04, 32'h1, 4'hF);
    chk("halt0_after_end", 32'(halt_o[0]), 32'h0);
    rdchk("done_collide", 8'h04, 32'h1);
    wr("w1c_done0_b", 8'h04, 32'h1, 4'hF);
    wr("ctrl0_off_c", 8'h40, 32'h0, 4'hF);
    chk("irq_after_w1c", 32'(irq_o), 32'h0);

    // ---------------- bus errors and byte enables ----------------
    bus(1'b0, 8'h60, 32'h0, 4'h0);
    chk("err_rd_slot2", 32'(er), 32'h1);
    chk("err_rd_slot2_rdata", rd, 32'h0);
    bus(1'b0, 8'h10, 32'h0, 4'h0);
    chk("err_rd_0x10", 32'(er), 32'h1);
    bus(1'b1, 8'h60, 32'hFFFF_FFFF, 4'hF);
    chk("err_wr_slot2", 32'(er), 32'h1);
    chk("err_wr_slot2_rdata", rd, 32'h0);
    wr("start0_be1", 8'h44, 32'hFFFF_FFFF, 4'h1);
    rdchk("start0_be1_rb", 8'h44, 32'h0000_00FF);
    wr("end0_be6", 8'h48, 32'hAABB_CCDD, 4'h6);
    rdchk("end0_be6_rb", 8'h48, 32'h00BB_CC0A);
    rdchk("period1_rb", 8'h5C, 32'd10);
    rdchk("irq_en_rb", 8'h0C, 32'h1);

    // ---------------- COUNT write while running ----------------
    wr("cnt_1000", 8'h00, 32'h1000, 4'hF);
    rdchk("count_written", 8'h00, 32'h1000);
    rdchk("count_incr", 8'h00, 32'h1001);
    wr("cnt_be2", 8'h00, 32'h0000_AB00, 4'h2);
    rdchk("count_be2", 8'h00, 32'h0000_AB02);

    // ---------------- asynchronous reset mid-window ----------------
    wr("start0_r", 8'h44, 32'h0, 4'hF);
    wr("end0_r", 8'h48, 32'h0010_0000, 4'hF);
    wr("end1_r", 8'h58, 32'h0010_0000, 4'hF);
    wr("ctrl0_r", 8'h40, 32'h1, 4'hF);
    wr("ctrl1_r", 8'h50, 32'h3, 4'hF);
    tick(2);
    chk("halt_pre_rst", 32'(halt_o), 32'h1);
    chk("rstn_pre_rst", 32'(core_rst_n_o), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("halt_async_rst", 32'(halt_o), 32'h0);
    chk("rstn_async_rst", 32'(core_rst_n_o), 32'h3);
    tick(1);
    rst = 1'b0;
    rdchk("count_after_rst", 8'h00, 32'd0);
    rdchk("gctrl_after_rst", 8'h08, 32'd1);
    rdchk("ctrl0_after_rst", 8'h40, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
